// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: one CALC iteration per cycle for 32 cycles,
// fixed 33-cycle latency for every op, result and destination index aimed at the register file.
module md_unit (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] SRC_A,
    input  logic [31:0] SRC_B,
    input  logic [4:0]  RD_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic [4:0]  RD_OUT,
    output logic        WE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic        b_zero_q, b_zero_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    // Operand decode at capture time: sign handling is done once on magnitudes.
    logic        in_a_signed, in_b_signed, in_a_neg, in_b_neg;
    logic [31:0] in_mag_a, in_mag_b;

    always_comb begin
        in_a_signed = (FUNCT3 == OP_MULH) || (FUNCT3 == OP_MULHSU) ||
                      (FUNCT3 == OP_DIV)  || (FUNCT3 == OP_REM);
        in_b_signed = (FUNCT3 == OP_MULH) || (FUNCT3 == OP_DIV) || (FUNCT3 == OP_REM);
        in_a_neg    = in_a_signed && SRC_A[31];
        in_b_neg    = in_b_signed && SRC_B[31];
        // 0x80000000 negates to itself, which read as unsigned is the correct 2^31 magnitude.
        in_mag_a    = in_a_neg ? (32'd0 - SRC_A) : SRC_A;
        in_mag_b    = in_b_neg ? (32'd0 - SRC_B) : SRC_B;
    end

    // One iteration: hi/lo hold the partial product or remainder/quotient pair.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_ok    = (div_shift >= {1'b0, mag_b_q});
        // The true difference is below the divisor, so 32 bits hold it exactly.
        div_diff  = div_shift[31:0] - mag_b_q;
        if (op_q[2]) begin
            step_hi = div_ok ? div_diff : div_shift[31:0];
            step_lo = {lo_q[30:0], div_ok};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo_q[31:1]};
        end
    end

    // Final result formed from the last iteration's outputs.
    logic [63:0] prod_s;
    logic [31:0] quot_s, rem_s, final_res;

    always_comb begin
        prod_s    = neg_q  ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
        quot_s    = neg_q  ? (32'd0 - step_lo) : step_lo;
        rem_s     = rneg_q ? (32'd0 - step_hi) : step_hi;
        final_res = 32'd0;
        case (op_q)
            OP_MUL:                      final_res = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[63:32];
            OP_DIV, OP_DIVU:             final_res = b_zero_q ? 32'hFFFF_FFFF : quot_s;
            OP_REM, OP_REMU:             final_res = b_zero_q ? a_q : rem_s;
            default:                     final_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_zero_d = b_zero_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_b_d  = mag_b_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d  = CALC;
                    cnt_d    = 5'd0;
                    op_d     = FUNCT3;
                    a_d      = SRC_A;
                    b_zero_d = (SRC_B == 32'd0);
                    neg_d    = in_a_neg ^ in_b_neg;
                    rneg_d   = in_a_neg;
                    hi_d     = 32'd0;
                    lo_d     = in_mag_a;
                    mag_b_d  = in_mag_b;
                    rd_d     = RD_IN;
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = FIN;
                    result_d = final_res;
                    rd_out_d = rd_q;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_zero_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mag_b_q  <= 32'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_zero_q <= b_zero_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_b_q  <= mag_b_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign BUSY   = (state_q != IDLE);
    assign DONE   = (state_q == FIN);
    assign RESULT = result_q;
    assign RD_OUT = rd_out_q;
    assign WE     = DONE && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: per-feature tasks with hand-computed results and
// cycle-exact BUSY/DONE/WE timing relative to the START cycle.
module tb_md_unit;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] SRC_A;
    logic [31:0] SRC_B;
    logic [4:0]  RD_IN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;
    logic        WE;

    int errors = 0;
    int checks = 0;

    int          obs_busy_cnt, obs_done_cnt, obs_done_at, obs_we_cnt;
    logic [31:0] obs_result;
    logic [4:0]  obs_rd;
    logic        obs_we;

    md_unit dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .FUNCT3 (FUNCT3),
        .SRC_A  (SRC_A),
        .SRC_B  (SRC_B),
        .RD_IN  (RD_IN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .RD_OUT (RD_OUT),
        .WE     (WE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives START in the current cycle T and observes cycles T+1..T+33; ends in T+33.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        FUNCT3 = f; SRC_A = a; SRC_B = b; RD_IN = rd; START = 1'b1;
        obs_busy_cnt = 0; obs_done_cnt = 0; obs_done_at = 0; obs_we_cnt = 0;
        obs_result = 'x; obs_rd = 'x; obs_we = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 1) begin
                START = 1'b0; SRC_A = ~a; SRC_B = ~b; RD_IN = ~rd; FUNCT3 = ~f;
            end
            if (BUSY === 1'b1) obs_busy_cnt++;
            if (WE === 1'b1) obs_we_cnt++;
            if (DONE === 1'b1) begin
                obs_done_cnt++;
                obs_done_at = k;
                obs_result  = RESULT;
                obs_rd      = RD_OUT;
                obs_we      = WE;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b1; FUNCT3 = 3'd0; SRC_A = 32'd3; SRC_B = 32'd3; RD_IN = 5'd1;
        tick();
        tick();
        checks++;
        if ({BUSY, DONE, WE} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: busy/done/we=%b required 000", {BUSY, DONE, WE});
        end
        checks++;
        if (RESULT !== 32'd0 || RD_OUT !== 5'd0) begin
            errors++; $display("FAIL reset_outputs: result=%h rd=%0d required 0/0", RESULT, RD_OUT);
        end
        RST_N = 1'b1; START = 1'b0;
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_start_ignored: busy=%b required 0", BUSY);
        end
        $display("test_reset done");
    endtask

    task automatic test_mul();
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        checks++;
        if (obs_busy_cnt !== 33 || obs_done_cnt !== 1 || obs_done_at !== 33) begin
            errors++;
            $display("FAIL mul_timing: busy=%0d done=%0d at=%0d required 33/1/33",
                     obs_busy_cnt, obs_done_cnt, obs_done_at);
        end
        checks++;
        if (obs_result !== 32'hFFFF_FFEB || obs_rd !== 5'd5) begin
            errors++; $display("FAIL mul_result: result=%h rd=%0d required ffffffeb/5", obs_result, obs_rd);
        end
        checks++;
        if (obs_we !== 1'b1 || obs_we_cnt !== 1) begin
            errors++; $display("FAIL mul_we: we=%b cycles=%0d required 1/1", obs_we, obs_we_cnt);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_after: busy=%b done=%b result=%h required 0/0/ffffffeb", BUSY, DONE, RESULT);
        end
        $display("test_mul result=%h", obs_result);
    endtask

    task automatic test_mul_high();
        logic [2:0]  f [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        f = '{3'b001, 3'b011, 3'b010, 3'b001};
        a = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        b = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        e = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], a[i], b[i], 5'd7);
            checks++;
            if (obs_result !== e[i] || obs_done_at !== 33 || obs_done_cnt !== 1) begin
                errors++;
                $display("FAIL mulhi_%0d: result=%h done_at=%0d required %h at 33", i, obs_result, obs_done_at, e[i]);
            end
            $display("test_mul_high op=%b a=%h b=%h result=%h", f[i], a[i], b[i], obs_result);
            tick();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f [6];
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [31:0] e [6];
        f = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        b = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        e = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1, 32'hFFFF_FFFD, 32'd1};
        for (int i = 0; i < 6; i++) begin
            do_op(f[i], a[i], b[i], 5'd12);
            checks++;
            if (obs_result !== e[i] || obs_done_at !== 33 || obs_we !== 1'b1) begin
                errors++;
                $display("FAIL div_%0d: result=%h done_at=%0d we=%b required %h at 33 we 1",
                         i, obs_result, obs_done_at, obs_we, e[i]);
            end
            $display("test_div op=%b a=%h b=%h result=%h", f[i], a[i], b[i], obs_result);
            tick();
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [5];
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [31:0] e [5];
        f = '{3'b101, 3'b111, 3'b100, 3'b100, 3'b110};
        a = '{32'd5, 32'd5, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        b = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            do_op(f[i], a[i], b[i], 5'd20);
            checks++;
            if (obs_result !== e[i] || obs_done_at !== 33 || obs_busy_cnt !== 33) begin
                errors++;
                $display("FAIL special_%0d: result=%h done_at=%0d busy=%0d required %h at 33 busy 33",
                         i, obs_result, obs_done_at, obs_busy_cnt, e[i]);
            end
            $display("test_special op=%b a=%h b=%h result=%h", f[i], a[i], b[i], obs_result);
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int done_at = 0;
        logic [31:0] res = 'x;
        logic [4:0]  rd = 'x;
        FUNCT3 = 3'b101; SRC_A = 32'd100; SRC_B = 32'd7; RD_IN = 5'd3; START = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            START = 1'b0;
            if (DONE === 1'b1) begin
                done_at = k; res = RESULT; rd = RD_OUT;
            end
            if (k == 5 || k == 33) begin
                START = 1'b1; FUNCT3 = 3'b000; SRC_A = 32'd9; SRC_B = 32'd9; RD_IN = 5'd9;
            end
        end
        tick();
        START = 1'b0;
        checks++;
        if (res !== 32'd14 || rd !== 5'd3 || done_at !== 33) begin
            errors++; $display("FAIL ignored_result: result=%h rd=%0d at=%0d required 0000000e/3/33", res, rd, done_at);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL ignored_in_fin: busy=%b required 0", BUSY);
        end
        $display("test_ignored_start result=%h", res);
    endtask

    task automatic test_abort();
        int seen = 0;
        FUNCT3 = 3'b000; SRC_A = 32'd6; SRC_B = 32'd6; RD_IN = 5'd4; START = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            START = 1'b0;
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        checks++;
        if (BUSY !== 1'b0 || RESULT !== 32'd0 || RD_OUT !== 5'd0) begin
            errors++; $display("FAIL abort_state: busy=%b result=%h rd=%0d required 0/0/0", BUSY, RESULT, RD_OUT);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (DONE !== 1'b0 || WE !== 1'b0 || BUSY !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_done: active cycles=%0d required 0", seen);
        end
        $display("test_abort done");
    endtask

    task automatic test_after_reset();
        do_op(3'b000, 32'd11, 32'd13, 5'd31);
        checks++;
        if (obs_result !== 32'd143 || obs_done_at !== 33 || obs_busy_cnt !== 33 || obs_rd !== 5'd31) begin
            errors++;
            $display("FAIL after_reset: result=%h at=%0d busy=%0d rd=%0d required 0000008f/33/33/31",
                     obs_result, obs_done_at, obs_busy_cnt, obs_rd);
        end
        $display("test_after_reset result=%h", obs_result);
        tick();
    endtask

    task automatic test_back_to_back();
        do_op(3'b000, 32'd3, 32'd4, 5'd0);
        checks++;
        if (obs_result !== 32'd12 || obs_done_at !== 33 || obs_we !== 1'b0 || obs_we_cnt !== 0) begin
            errors++;
            $display("FAIL rd0_op: result=%h at=%0d we=%b required 0000000c/33/0", obs_result, obs_done_at, obs_we);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL rd0_idle: busy=%b required 0", BUSY);
        end
        do_op(3'b011, 32'h0001_0000, 32'h0003_0000, 5'd2);
        checks++;
        if (obs_result !== 32'd3 || obs_done_at !== 33 || obs_we !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: result=%h at=%0d we=%b required 00000003/33/1", obs_result, obs_done_at, obs_we);
        end
        $display("test_back_to_back result=%h", obs_result);
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_ignored_start();
        test_abort();
        test_after_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLK (rising edge) and RST_N.
REQ-002 Port list SHALL be:
  CLK     in   1   clock, rising edge
  RST_N   in   1   synchronous reset, active low
  START   in   1   request; sampled on rising CLK
  FUNCT3  in   3   op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
  SRC_A   in   32  operand A / dividend, fed from register-file RD1
  SRC_B   in   32  operand B / divisor, fed from register-file RD2
  RD_IN   in   5   destination register index
  BUSY    out  1   operation in progress
  DONE    out  1   one-cycle result-valid pulse
  RESULT  out  32  result, feeds register-file WD3
  RD_OUT  out  5   destination index, feeds register-file A3
  WE      out  1   write enable, feeds register-file WE3

Function
REQ-003 The state machine SHALL have states IDLE, CALC and FIN; BUSY = (state != IDLE); DONE = (state == FIN).
REQ-004 In IDLE, START=1 at a rising edge SHALL capture FUNCT3, SRC_A, SRC_B and RD_IN and move to CALC; input changes after capture SHALL have no effect.
REQ-005 START SHALL be ignored while BUSY=1, including in FIN.
REQ-006 CALC SHALL last exactly 32 cycles: one iteration per cycle, 5-bit counter, shift-add multiply or restoring divide on operand magnitudes. It SHALL then move to FIN, and FIN SHALL move to IDLE after 1 cycle.
REQ-007 Latency SHALL be fixed: START sampled at the edge ending cycle T gives BUSY=1 in cycles T+1..T+33 and DONE=1 only in cycle T+33. This SHALL hold for every op and every operand value, including the special cases.
REQ-008 RESULT and RD_OUT SHALL be valid in the DONE cycle and SHALL hold that value until the next accepted START. RESULT SHALL not be guaranteed while in CALC.
REQ-009 WE SHALL equal DONE AND (RD_OUT != 0).
REQ-010 Multiply SHALL form a 64-bit product P:
  - MUL gives P[31:0].
  - MULH gives P[63:32] with signed x signed.
  - MULHSU gives P[63:32] with signed A x unsigned B.
  - MULHU gives P[63:32] with unsigned x unsigned.
REQ-011 Signed divide (DIV/REM) SHALL truncate toward zero: quotient is negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-012 Divide by zero SHALL give: DIV and DIVU = 0xFFFFFFFF; REM and REMU = SRC_A unchanged.
REQ-013 Signed overflow (SRC_A=0x80000000, SRC_B=0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-014 Operand value 0x80000000 SHALL be handled correctly in all signed ops; its magnitude SHALL be 2^31, held in at least 33 bits or as unsigned.

Reset
REQ-015 RST_N=0 at a rising edge SHALL force: state IDLE, counter 0, BUSY=0, DONE=0, WE=0, RESULT=0, RD_OUT=0, internal datapath registers 0.
REQ-016 Reset in CALC or FIN SHALL abandon the operation with no DONE and no WE. START sampled together with RST_N=0 SHALL be ignored.
REQ-017 After RST_N returns high, the first START SHALL be accepted with full REQ-007 timing.

Verification
REQ-018 MUL: SRC_A=7, SRC_B=0xFFFFFFFD (-3), RD_IN=5, START in cycle T -> BUSY 1 in T+1..T+33; DONE, WE 1 only in T+33; RESULT=0xFFFFFFEB; RD_OUT=5.
REQ-019 High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-020 Signed and unsigned divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU same operands -> 1.
REQ-021 Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each of these with DONE in T+33.
REQ-022 Abort and ignored requests:
  - START with new operands in T+5 and again in FIN -> ignored; result matches the first op.
  - RST_N=0 in T+10 -> BUSY=0 in T+11 and no DONE or WE follows.
REQ-023 RD_IN=0 with MUL 3x4 -> DONE=1, RESULT=12, WE=0 in T+33; a new START in T+34 (IDLE) is accepted.
